// File: rtl/case_pattern_enum.sv
// Enumerates every 3-bit source pattern that decodes to a requested class,
// using either a plain case table (A) or a first-match casez table (B).
module case_pattern_enum #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_sel,
    input  logic [2:0]       req_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_pat,
    output logic             out_none,
    output logic             out_last,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       mask_q, mask_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic [7:0]       matchMask;
    logic [2:0]       lowIdx;
    logic             maskEmpty;
    logic             maskOneHot;
    logic             emitting;
    logic             accept;
    logic             handshake;
    logic             lastBeat;

    function automatic logic [2:0] decodeA(input logic [2:0] pat);
        logic [2:0] code;
        case (pat)
            3'd0:                code = 3'd0;
            3'd1, 3'd2, 3'd3:    code = 3'd1;
            3'd4, 3'd5, 3'd6:    code = 3'd2;
            default:             code = 3'd3;
        endcase
        return code;
    endfunction

    function automatic logic [2:0] decodeB(input logic [2:0] pat);
        logic [2:0] code;
        casez (pat)
            3'b00?:  code = 3'd0;
            3'b0?1:  code = 3'd1;
            3'b?10:  code = 3'd2;
            3'b1??:  code = 3'd3;
            default: code = 3'd4;
        endcase
        return code;
    endfunction

    // Which of the eight source patterns decode to the requested class.
    always_comb begin
        matchMask = '0;
        for (int i = 0; i < 8; i++) begin
            if (req_sel) begin
                matchMask[i] = (decodeB(3'(i)) == req_code);
            end else begin
                matchMask[i] = (decodeA(3'(i)) == req_code);
            end
        end
    end

    always_comb begin
        lowIdx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) begin
                lowIdx = 3'(i);
            end
        end
    end

    assign maskEmpty  = (mask_q == 8'd0);
    assign maskOneHot = !maskEmpty && ((mask_q & (mask_q - 8'd1)) == 8'd0);
    assign emitting   = (state_q == EMIT);
    assign accept     = req_valid && req_ready;
    assign handshake  = out_valid && out_ready;
    assign lastBeat   = maskEmpty || maskOneHot;

    // Outputs depend only on registered state, never on the request inputs.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        beat_cnt_d = beat_cnt_q;
        req_ready  = (state_q == IDLE);
        out_valid  = emitting;
        out_pat    = (emitting && !maskEmpty) ? lowIdx : 3'd0;
        out_none   = emitting && maskEmpty;
        out_last   = emitting && lastBeat;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EMIT;
                    mask_d  = matchMask;
                end
            end
            EMIT: begin
                if (handshake) begin
                    mask_d = mask_q & (mask_q - 8'd1);
                    if (lastBeat) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                mask_d  = '0;
            end
        endcase

        if (handshake) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;

endmodule
